// File: rtl/multi_edge_pulse_gen.sv
// Multi-channel synchronise / debounce / edge-pulse generator for push-buttons.
// Optional auto-repeat on held press: define MULTI_EDGE_PULSE_GEN_REPEAT_EN.
module multi_edge_pulse_gen #(
    parameter int N_CH             = 4,
    parameter int DEB_CYCLES       = 16,
    parameter int EDGE_MODE        = 0,
    parameter int PULSE_ACTIVE_LOW = 1,
    parameter int REPEAT_DELAY     = 50000000,
    parameter int REPEAT_PERIOD    = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] level_in,
    output logic [N_CH-1:0] level_db,
    output logic [N_CH-1:0] pulse_out,
    output logic            any_pulse
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic IDLE_LVL = (PULSE_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_HELD
    } state_t;

    if (N_CH < 1 || DEB_CYCLES < 1 || EDGE_MODE < 0 || EDGE_MODE > 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("multi_edge_pulse_gen: invalid parameter set");
    end

    logic [N_CH-1:0] w_pulse;

    assign any_pulse = |w_pulse;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic             r_db;
        logic [CNT_W-1:0] r_cnt;
        logic             r_pulse_out;
        state_t           r_state;
        state_t           w_state_nx;
        logic             w_flip;
        logic             w_qual;
        logic             w_rep_hit;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                r_sync1 <= level_in[g];
                r_sync2 <= r_sync1;
            end
        end

        // Any sample that agrees with the accepted level restarts the window.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_db  <= 1'b1;
                r_cnt <= '0;
            end else if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_db  <= ~r_db;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_flip = (r_sync2 != r_db) && (r_cnt == DEB_LAST);
        assign w_qual = (EDGE_MODE == 2) ? w_flip :
                        (EDGE_MODE == 1) ? (w_flip && !r_db) :
                                           (w_flip && r_db);

`ifdef MULTI_EDGE_PULSE_GEN_REPEAT_EN
        localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                 REPEAT_DELAY : REPEAT_PERIOD;
        localparam int REP_W = $clog2(REP_MAX + 1);

        logic [REP_W-1:0] r_rep;
        logic             r_first;
        logic [REP_W-1:0] w_rep_tgt;

        assign w_rep_tgt = r_first ? REP_W'(REPEAT_DELAY - 1) :
                                     REP_W'(REPEAT_PERIOD - 1);
        assign w_rep_hit = (EDGE_MODE != 1) && !w_flip && !r_db &&
                           (r_state != ST_IDLE) && (r_rep == w_rep_tgt);

        // Counts cycles since the last press or repeat pulse while held.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rep   <= '0;
                r_first <= 1'b1;
            end else if (w_flip || r_db) begin
                r_rep   <= '0;
                r_first <= 1'b1;
            end else if (w_rep_hit) begin
                r_rep   <= '0;
                r_first <= 1'b0;
            end else if (r_state != ST_IDLE) begin
                r_rep <= r_rep + REP_W'(1);
            end
        end
`else
        assign w_rep_hit = 1'b0;
`endif

        always_comb begin
            w_state_nx = r_state;
            unique case (1'b1)
                w_flip: begin
                    if (w_qual) begin
                        w_state_nx = ST_PULSE;
                    end else begin
                        w_state_nx = r_db ? ST_HELD : ST_IDLE;
                    end
                end
                w_rep_hit: begin
                    w_state_nx = ST_PULSE;
                end
                (r_state == ST_PULSE): begin
                    w_state_nx = r_db ? ST_IDLE : ST_HELD;
                end
                default: begin
                    w_state_nx = r_state;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state     <= ST_IDLE;
                r_pulse_out <= IDLE_LVL;
            end else begin
                r_state     <= w_state_nx;
                r_pulse_out <= (w_state_nx == ST_PULSE) ^ IDLE_LVL;
            end
        end

        assign w_pulse[g]   = (r_state == ST_PULSE);
        assign level_db[g]  = r_db;
        assign pulse_out[g] = r_pulse_out;
    end

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Scoreboard bench for multi_edge_pulse_gen: two configurations, a timestamp
// reference model, random stimulus plus directed press/bounce/reset scenarios.
module tb_multi_edge_pulse_gen;

    localparam int NC = 4;
    localparam int P_DEB  [2] = '{16, 3};
    localparam int P_MODE [2] = '{0, 2};
    localparam int P_AL   [2] = '{1, 0};
    localparam int P_RD   [2] = '{100, 30};
    localparam int P_RP   [2] = '{20, 7};
    localparam int DEB_A = 16;

    typedef struct packed {
        logic [NC-1:0] db;
        logic [NC-1:0] po;
        logic          any;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] lvl_a, lvl_b;
    logic [NC-1:0] db_a, po_a, db_b, po_b;
    logic          any_a, any_b;

    always #5 clk = ~clk;

    multi_edge_pulse_gen #(
        .N_CH(NC), .DEB_CYCLES(16), .EDGE_MODE(0), .PULSE_ACTIVE_LOW(1),
        .REPEAT_DELAY(100), .REPEAT_PERIOD(20)
    ) u_dut_a (
        .clk(clk), .rst(rst), .level_in(lvl_a),
        .level_db(db_a), .pulse_out(po_a), .any_pulse(any_a)
    );

    multi_edge_pulse_gen #(
        .N_CH(NC), .DEB_CYCLES(3), .EDGE_MODE(2), .PULSE_ACTIVE_LOW(0),
        .REPEAT_DELAY(30), .REPEAT_PERIOD(7)
    ) u_dut_b (
        .clk(clk), .rst(rst), .level_in(lvl_b),
        .level_db(db_b), .pulse_out(po_b), .any_pulse(any_b)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state: input delay line, last agreeing edge, next repeat edge.
    bit m_p1 [2][NC];
    bit m_p2 [2][NC];
    bit m_db [2][NC];
    int m_agree [2][NC];
    int m_rep [2][NC];

    // Observed statistics for configuration A.
    int a_pcyc [NC][$];
    int a_pcnt [NC];
    int a_dbchg [NC];
    int a_any_cnt;
    int a_both03;
    logic [NC-1:0] a_db_prev = '1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int d, input logic [NC-1:0] lv,
                              output exp_t e);
        bit samp, pl, press;
        e = '0;
        for (int c = 0; c < NC; c++) begin
            pl = 1'b0;
            if (rst) begin
                m_p1[d][c] = 1'b1;
                m_p2[d][c] = 1'b1;
                m_db[d][c] = 1'b1;
                m_agree[d][c] = cyc;
                m_rep[d][c] = -1;
            end else begin
                samp = m_p2[d][c];
                m_p2[d][c] = m_p1[d][c];
                m_p1[d][c] = lv[c];
                if (samp == m_db[d][c]) begin
                    m_agree[d][c] = cyc;
                end else if (cyc - m_agree[d][c] >= P_DEB[d]) begin
                    press = m_db[d][c];
                    m_db[d][c] = ~m_db[d][c];
                    m_agree[d][c] = cyc;
                    pl = (P_MODE[d] == 2) || (P_MODE[d] == 0 && press) ||
                         (P_MODE[d] == 1 && !press);
                    m_rep[d][c] = -1;
`ifdef MULTI_EDGE_PULSE_GEN_REPEAT_EN
                    if (press && pl) m_rep[d][c] = cyc + P_RD[d];
`endif
                end else if (P_MODE[d] != 1 && !m_db[d][c] &&
                             m_rep[d][c] == cyc) begin
                    pl = 1'b1;
                    m_rep[d][c] = cyc + P_RP[d];
                end
            end
            e.db[c] = m_db[d][c];
            e.po[c] = pl ^ (P_AL[d] != 0);
            e.any   = e.any | pl;
        end
    endtask

    initial begin
        exp_t ea, eb;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            model_step(0, lvl_a, ea);
            model_step(1, lvl_b, eb);
            q_a.push_back(ea);
            q_b.push_back(eb);
        end
    end

    task automatic sb_compare(input string name, input exp_t act,
                              input exp_t e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL sb_%s cycle %0d: db=%h po=%h any=%b, expected db=%h po=%h any=%b",
                     name, cyc, act.db, act.po, act.any, e.db, e.po, e.any);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                if (q_a.size() == 0 || q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got no expected entry at cycle %0d", cyc);
                end else begin
                    sb_compare("a", {db_a, po_a, any_a}, q_a.pop_front());
                    sb_compare("b", {db_b, po_b, any_b}, q_b.pop_front());
                end
                for (int c = 0; c < NC; c++) begin
                    if (!po_a[c]) begin
                        a_pcnt[c]++;
                        a_pcyc[c].push_back(cyc);
                    end
                    if (db_a[c] != a_db_prev[c]) a_dbchg[c]++;
                end
                a_db_prev = db_a;
                if (any_a) a_any_cnt++;
                if (!po_a[0] && !po_a[3]) a_both03++;
            end
        end
    end

    task automatic clear_stats();
        for (int c = 0; c < NC; c++) begin
            a_pcyc[c].delete();
            a_pcnt[c] = 0;
            a_dbchg[c] = 0;
        end
        a_any_cnt = 0;
        a_both03 = 0;
    endtask

    function automatic int nth_pulse(input int c, input int n);
        return (a_pcyc[c].size() > n) ? a_pcyc[c][n] : -1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int rel, k;
    int rcnt [2][NC];

    initial begin
        lvl_a = '0;
        lvl_b = '0;
        clear_stats();
        step(3);
        check("rst_level_db", int'(db_a), 15);
        check("rst_pulse_out_a", int'(po_a), 15);
        check("rst_pulse_out_b", int'(po_b), 0);
        check("rst_any_pulse", int'(any_a), 0);

        // Release reset with every button held: fresh press, first edge is k.
        @(negedge clk);
        #1 rst = 1'b0;
        rel = cyc;
        clear_stats();
        step(DEB_A + 10);
        check("rel_first_pulse", nth_pulse(0, 0), rel + 1 + 1 + DEB_A);
        check("rel_pulse_cnt", a_pcnt[0], 1);
        check("rel_any_cnt", a_any_cnt, 1);
        lvl_a = '1;
        lvl_b = '1;
        step(40);

        // Clean press on ch0, long hold, then release.
        clear_stats();
        lvl_a[0] = 1'b0;
        lvl_b[0] = 1'b0;
        k = cyc + 1;
        step(990);
        check("press_edge", nth_pulse(0, 0), k + 1 + DEB_A);
`ifdef MULTI_EDGE_PULSE_GEN_REPEAT_EN
        check("repeat_delay", nth_pulse(0, 1) - nth_pulse(0, 0), 100);
        check("repeat_period", nth_pulse(0, 2) - nth_pulse(0, 1), 20);
`else
        check("hold_pulse_cnt", a_pcnt[0], 1);
`endif
        clear_stats();
        lvl_a[0] = 1'b1;
        lvl_b[0] = 1'b1;
        step(40);
        check("release_no_pulse", a_pcnt[0], 0);
        check("release_db", int'(db_a[0]), 1);

        // Bouncing ch1, then a clean settle low.
        clear_stats();
        for (int i = 0; i < 40; i++) begin
            lvl_a[1] = ~lvl_a[1];
            lvl_b[1] = lvl_a[1];
            step(5);
        end
        check("bounce_db_stable", a_dbchg[1], 0);
        check("bounce_no_pulse", a_pcnt[1], 0);
        lvl_a[1] = 1'b0;
        lvl_b[1] = 1'b0;
        k = cyc + 1;
        step(40);
        check("bounce_pulse_cnt", a_pcnt[1], 1);
        check("bounce_pulse_edge", nth_pulse(1, 0), k + 1 + DEB_A);
        lvl_a[1] = 1'b1;
        lvl_b[1] = 1'b1;
        step(40);

        // Simultaneous press on ch0 and ch3.
        clear_stats();
        lvl_a[0] = 1'b0;
        lvl_a[3] = 1'b0;
        lvl_b = lvl_a;
        step(40);
        check("simul_any_cnt", a_any_cnt, 1);
        check("simul_same_cycle", a_both03, 1);
        lvl_a = '1;
        lvl_b = '1;
        step(40);

        // Reset in the middle of a debounce window on ch2.
        lvl_a[2] = 1'b0;
        lvl_b[2] = 1'b0;
        step(8);
        @(negedge clk);
        #1 rst = 1'b1;
        step(3);
        check("abort_db", int'(db_a[2]), 1);
        check("abort_pulse_out", int'(po_a[2]), 1);
        @(negedge clk);
        #1 rst = 1'b0;
        rel = cyc;
        clear_stats();
        step(40);
        check("abort_fresh_press", nth_pulse(2, 0), rel + 1 + 1 + DEB_A);
        check("abort_pulse_cnt", a_pcnt[2], 1);
        lvl_a = '1;
        lvl_b = '1;
        step(40);

        // Random mix of short bounces and long holds on both configurations.
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NC; c++) rcnt[d][c] = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                @(negedge clk);
                #1 rst = 1'b1;
                step(2);
                @(negedge clk);
                #1 rst = 1'b0;
                step(1);
            end
            for (int c = 0; c < NC; c++) begin
                if (rcnt[0][c] == 0) begin
                    lvl_a[c] = 1'($urandom_range(0, 1));
                    rcnt[0][c] = ($urandom_range(0, 3) == 0) ?
                                 int'($urandom_range(20, 150)) :
                                 int'($urandom_range(1, 6));
                end
                if (rcnt[1][c] == 0) begin
                    lvl_b[c] = 1'($urandom_range(0, 1));
                    rcnt[1][c] = int'($urandom_range(1, 12));
                end
                rcnt[0][c]--;
                rcnt[1][c]--;
            end
            step(1);
        end
        step(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_edge_pulse_gen.md
Name: multi_edge_pulse_gen

Overview:
- Parameterised, multi-channel successor to the single-channel level-to-pulse converter.
- Per channel:
  - synchronises an asynchronous button/level input;
  - debounces it over a programmable window;
  - emits exactly one single-clock pulse on the selected edge(s).
- Sits between the board push-buttons and the PWM brightness controller, so up/down/mode buttons all share one block.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- DEB_CYCLES, 16, consecutive stable synchronised samples needed to accept a level change (>=1).
- EDGE_MODE, 0, 0 = press (1->0), 1 = release (0->1), 2 = both edges.
- PULSE_ACTIVE_LOW, 1, 1 = pulse_out idles 1 and pulses 0; 0 = idles 0 and pulses 1.
- REPEAT_DELAY, 50000000, cycles from the press pulse to the first repeat pulse (used only with REPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (used only with REPEAT_EN).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- level_in  input  N_CH  raw asynchronous levels; buttons are active-low (0 = pressed).
- level_db  output  N_CH  debounced, synchronised level per channel.
- pulse_out  output  N_CH  per-channel single-cycle pulse; polarity set by PULSE_ACTIVE_LOW.
- any_pulse  output  1  active-high OR of all channel pulses (combinational from internal pulse flags).

Behaviour:
- Reset (rst=1, async):
  - sync flops, level_db = all 1s (idle);
  - debounce counters = 0; channel FSMs = IDLE;
  - pulse_out = all idle level; any_pulse = 0; repeat counters = 0.
- Synchroniser: two flops per channel, reset to 1.
- Debounce, per channel; counter width = clog2(DEB_CYCLES+1):
  - sync2 == level_db: counter cleared.
  - Mismatch and counter < DEB_CYCLES-1: increment.
  - Mismatch and counter == DEB_CYCLES-1: level_db flips, counter cleared.
  - Any single agreeing sample restarts the window (glitch rejection).
- Latency: level_in settles to a new value before edge k -> level_db changes at edge k+1+DEB_CYCLES.
  - Example: DEB_CYCLES=16 -> edge k+17.
- Pulse generation:
  - Internal pulse flag set on the same edge that level_db flips, when that edge matches EDGE_MODE.
  - Flag is cleared on the next edge, giving exactly one cycle.
  - pulse_out is registered (no glitches): flag XOR PULSE_ACTIVE_LOW, i.e. inverted when active-low.
- Channel FSM: IDLE -> PULSE (qualifying edge) -> HELD (level not yet returned) -> IDLE (opposite debounced edge).
  - In EDGE_MODE 2 the return edge from HELD also passes through PULSE.
  - A non-qualifying edge moves directly between IDLE and HELD with no pulse.
- Channels are fully independent. Simultaneous edges on several channels pulse in the same cycle; any_pulse is asserted once for that cycle.
- A held input generates no further pulses; it stays in HELD regardless of duration (unless REPEAT_EN).
- Reset asserted mid-debounce or mid-pulse aborts immediately and returns to reset values. No pulse is emitted on release of reset, even if level_in is low at that time; the low level is debounced as a fresh press.

Optional Feature:
- Macro: MULTI_EDGE_PULSE_GEN_REPEAT_EN.
- Defined (auto-repeat):
  - Applies only to EDGE_MODE 0 and 2, and only to press.
  - While a channel stays pressed after its press pulse: after REPEAT_DELAY cycles, one further pulse; then one every REPEAT_PERIOD cycles.
  - Repeat counter is per channel, width clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - Release clears the counter with no extra repeat pulse. With EDGE_MODE 2, the normal release pulse is still generated.
- Undefined: no repeat logic or counters synthesised; behaviour as above.

Test Plan:
- Reset sanity: rst=1 with level_in=0 -> level_db=4'hF, pulse_out=4'hF, any_pulse=0. Release rst with level_in held 0 -> first press pulse at edge 1+DEB_CYCLES after release, not before.
- Clean press, DEB_CYCLES=16, EDGE_MODE 0: ch0 1->0 before edge k -> level_db[0]=0 and pulse_out[0]=0 at edge k+17 for exactly one cycle. Hold for 1000 cycles -> no further pulses. Release -> no pulse.
- Bounce rejection: ch1 toggles every 5 cycles for 200 cycles, then settles to 0 -> exactly one pulse, 17 edges after the final settle; level_db[1] never changes during bouncing.
- EDGE_MODE 2, PULSE_ACTIVE_LOW 0: press then release on ch2 -> two active-high one-cycle pulses, one per debounced edge; any_pulse mirrors both.
- Simultaneous channels: ch0 and ch3 pressed on the same edge -> pulse_out[0] and pulse_out[3] asserted in the same cycle; any_pulse=1 for exactly that one cycle.
- REPEAT_EN build, REPEAT_DELAY=100, REPEAT_PERIOD=20: hold ch0 for 200 cycles after the press pulse -> repeat pulses at +100, +120, +140, +160, +180, +200. Release -> none further.
